// File: rtl/rgmii_tx_sched.sv
// rgmii_tx_sched: two-requester round-robin frame scheduler for an RGMII TX datapath.
// Each granted frame is sent as PREAMBLE_LEN x 0x55, one 0xD5 SFD byte, then the
// payload bytes. A gap of IFG_CYCLES idle clocks follows each frame.
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   req0/req1           - frame request per requester
//   gnt0/gnt1           - registered grant, held from PREAMBLE through DATA
//   d0/d1, v0/v1        - payload byte and valid per requester
//   last0/last1         - final payload byte marker, qualified by vN
//   rdy0/rdy1           - combinational accept strobe (DATA state and granted)
//   tx_en, tx_er, tx_d  - registered RGMII transmit outputs
//   busy                - high whenever the scheduler is not IDLE
//   frame_cnt           - completed frames, wraps
//   underrun_cnt        - aborted frames, saturates at 0xFF
module rgmii_tx_sched #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    input  logic        v0,
    input  logic        v1,
    input  logic        last0,
    input  logic        last1,
    output logic        rdy0,
    output logic        rdy1,
    output logic        tx_en,
    output logic        tx_er,
    output logic [7:0]  tx_d,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  underrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_IFG
    } state_e;

    state_e      state_q, state_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        prio1_q, prio1_d;   // 1: requester 1 wins the next tie
    logic [15:0] cnt_q, cnt_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  underrun_cnt_q, underrun_cnt_d;

    logic        pick1;
    logic        sel_v;
    logic        sel_last;
    logic [7:0]  sel_d;

    // Payload source follows the current grant.
    assign sel_v    = gnt1_q ? v1    : v0;
    assign sel_last = gnt1_q ? last1 : last0;
    assign sel_d    = gnt1_q ? d1    : d0;

    // TX outputs are registered from the current state, so the wire image
    // lags the state by one clock and payload bytes follow the SFD back to back.
    always_comb begin
        state_d        = state_q;
        gnt0_d         = gnt0_q;
        gnt1_d         = gnt1_q;
        prio1_d        = prio1_q;
        cnt_d          = cnt_q;
        tx_en_d        = 1'b0;
        tx_er_d        = 1'b0;
        tx_d_d         = 8'h00;
        frame_cnt_d    = frame_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        pick1          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    pick1   = req1 && (!req0 || prio1_q);
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    prio1_d = !pick1;
                    cnt_d   = '0;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                tx_d_d  = 8'h55;
                if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                tx_d_d  = 8'hD5;
                state_d = S_DATA;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (sel_v) begin
                    tx_d_d = sel_d;
                    if (sel_last) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gnt0_d      = 1'b0;
                        gnt1_d      = 1'b0;
                        cnt_d       = '0;
                        state_d     = S_IFG;
                    end
                end else begin
                    // Any DATA clock without a byte aborts the frame.
                    tx_er_d = 1'b1;
                    if (underrun_cnt_q != 8'hFF) begin
                        underrun_cnt_d = underrun_cnt_q + 8'd1;
                    end
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt_q == 16'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            prio1_q        <= 1'b0;
            cnt_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            tx_d_q         <= '0;
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            gnt0_q         <= gnt0_d;
            gnt1_q         <= gnt1_d;
            prio1_q        <= prio1_d;
            cnt_q          <= cnt_d;
            tx_en_q        <= tx_en_d;
            tx_er_q        <= tx_er_d;
            tx_d_q         <= tx_d_d;
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign rdy0         = (state_q == S_DATA) && gnt0_q;
    assign rdy1         = (state_q == S_DATA) && gnt1_q;
    assign tx_en        = tx_en_q;
    assign tx_er        = tx_er_q;
    assign tx_d         = tx_d_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Testbench for rgmii_tx_sched: per-clock vector table for a single frame and an
// underrun frame, plus hand sequences for arbitration, streaming, reset and counters.
module tb_rgmii_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, v0, v1, last0, last1;
    logic [7:0]  d0, d1;
    logic        gnt0, gnt1, rdy0, rdy1, tx_en, tx_er, busy;
    logic [7:0]  tx_d;
    logic [15:0] frame_cnt;
    logic [7:0]  underrun_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rgmii_tx_sched #(
        .PREAMBLE_LEN(7),
        .IFG_CYCLES  (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .d0          (d0),
        .d1          (d1),
        .v0          (v0),
        .v1          (v1),
        .last0       (last0),
        .last1       (last1),
        .rdy0        (rdy0),
        .rdy1        (rdy1),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .tx_d        (tx_d),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .underrun_cnt(underrun_cnt)
    );

    // in_b: {req0,req1,v0,v1,last0,last1}; ex_b: {gnt0,gnt1,rdy0,rdy1,tx_en,tx_er}
    typedef struct {
        string      nm;
        logic [5:0] in_b;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [5:0] ex_b;
        logic [7:0] txd;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic addv(input string nm, input logic [5:0] in_b, input logic [7:0] dd0,
                        input logic [7:0] dd1, input logic [5:0] ex_b,
                        input logic [7:0] txd, input logic bsy);
        vec_t r;
        r.nm = nm; r.in_b = in_b; r.d0 = dd0; r.d1 = dd1;
        r.ex_b = ex_b; r.txd = txd; r.busy = bsy;
        vq.push_back(r);
    endtask

    // Never both grants at once.
    always @(negedge clk) begin
        if (gnt0 && gnt1) begin
            n_total++;
            $display("FAIL both_gnt: got gnt0=%0b gnt1=%0b, expected at most one", gnt0, gnt1);
        end
    end

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        last0 = 1'b0; last1 = 1'b0; d0 = '0; d1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a grant, checks who got it, then streams n bytes starting at base.
    task automatic send(input int who, input int n, input logic [7:0] base);
        int         k;
        int         rdy_cnt;
        logic [7:0] exp_b;
        k = 0;
        while (!(gnt0 || gnt1) && k < 60) begin @(negedge clk); k++; end
        chk("grant_wait", 32'(k < 60), 32'd1);
        chk("grant_who", 32'({gnt0, gnt1}), (who == 0) ? 32'd2 : 32'd1);
        k = 0;
        while (!(rdy0 || rdy1) && k < 20) begin @(negedge clk); k++; end
        chk("rdy_wait", 32'(k < 20), 32'd1);
        rdy_cnt = 0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                exp_b = base + 8'(i - 1);
                chk("stream_byte", 32'({tx_en, tx_er, tx_d}), 32'({2'b10, exp_b}));
            end
            if (i < n) begin
                if ((who == 0) ? rdy0 : rdy1) rdy_cnt++;
                if (who == 0) begin v0 = 1'b1; d0 = base + 8'(i); last0 = (i == n - 1); end
                else          begin v1 = 1'b1; d1 = base + 8'(i); last1 = (i == n - 1); end
                @(negedge clk);
            end else begin
                v0 = 1'b0; v1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
            end
        end
        chk("rdy_cycles", 32'(rdy_cnt), 32'(n));
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 60) begin @(negedge clk); k++; end
        chk(nm, 32'(k < 60), 32'd1);
    endtask

    task automatic underrun_frame();
        int k;
        req0 = 1'b1;
        k = 0;
        while (!gnt0 && k < 60) begin @(negedge clk); k++; end
        req0 = 1'b0;
        chk("uf_grant", 32'(k < 60), 32'd1);
        @(negedge clk);
        wait_idle("uf_done");
    endtask

    initial begin
        int   pc;
        logic stop;

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single frame 0x11,0x22,0x33 from requester 0; req1 pulse during PREAMBLE ignored.
        addv("A_reset", 6'b100000, 8'h00, 8'h00, 6'b000000, 8'h00, 1'b0);
        addv("A_grant", 6'b010000, 8'h00, 8'h00, 6'b100000, 8'h00, 1'b1);
        addv("A_pre",   6'b010000, 8'h00, 8'h00, 6'b100010, 8'h55, 1'b1);
        for (int i = 0; i < 6; i++) addv("A_pre", 6'b000000, 8'h00, 8'h00, 6'b100010, 8'h55, 1'b1);
        addv("A_sfd",   6'b001000, 8'h11, 8'h00, 6'b101010, 8'hD5, 1'b1);
        addv("A_d1",    6'b001000, 8'h22, 8'h00, 6'b101010, 8'h11, 1'b1);
        addv("A_d2",    6'b001010, 8'h33, 8'h00, 6'b101010, 8'h22, 1'b1);
        addv("A_d3",    6'b000000, 8'h00, 8'h00, 6'b000010, 8'h33, 1'b1);
        for (int i = 0; i < 11; i++) addv("A_ifg", 6'b000000, 8'h00, 8'h00, 6'b000000, 8'h00, 1'b1);
        addv("A_idle",  6'b010000, 8'h00, 8'h00, 6'b000000, 8'h00, 1'b0);
        // Requester 1 underruns on its first DATA clock.
        addv("B_grant", 6'b000000, 8'h00, 8'h00, 6'b010000, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) addv("B_pre", 6'b000000, 8'h00, 8'h00, 6'b010010, 8'h55, 1'b1);
        addv("B_sfd",   6'b000000, 8'h00, 8'h77, 6'b010110, 8'hD5, 1'b1);
        addv("B_under", 6'b000000, 8'h00, 8'h00, 6'b000011, 8'h00, 1'b1);
        for (int i = 0; i < 11; i++) addv("B_ifg", 6'b000000, 8'h00, 8'h00, 6'b000000, 8'h00, 1'b1);
        addv("B_idle",  6'b000000, 8'h00, 8'h00, 6'b000000, 8'h00, 1'b0);

        foreach (vq[i]) begin
            @(negedge clk);
            {req0, req1, v0, v1, last0, last1} = vq[i].in_b;
            d0 = vq[i].d0;
            d1 = vq[i].d1;
            #1;
            chk(vq[i].nm, 32'({gnt0, gnt1, rdy0, rdy1, tx_en, tx_er, tx_d, busy}),
                32'({vq[i].ex_b, vq[i].txd, vq[i].busy}));
        end
        chk("AB_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("AB_underrun_cnt", 32'(underrun_cnt), 32'd1);

        // Contention from reset: 0, then 1, then 0 again.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        send(0, 1, 8'hA0);
        send(1, 1, 8'hB0);
        send(0, 1, 8'hC0);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle("C_idle");
        chk("C_frame_cnt", 32'(frame_cnt), 32'd3);

        // 64-byte back-to-back payload.
        req0 = 1'b1;
        send(0, 64, 8'h40);
        req0 = 1'b0;
        wait_idle("D_idle");
        chk("D_frame_cnt", 32'(frame_cnt), 32'd4);

        // frame_cnt wrap.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        chk("E_preload", 32'(frame_cnt), 32'hFFFF);
        req0 = 1'b1;
        send(0, 1, 8'h5A);
        req0 = 1'b0;
        chk("E_wrap", 32'(frame_cnt), 32'h0000);
        wait_idle("E_idle");

        // Reset after two payload bytes truncates cleanly.
        do_reset();
        req0 = 1'b1;
        send(0, 0, 8'h00);
        req0 = 1'b0;
        v0 = 1'b1; d0 = 8'hE1; @(negedge clk);
        v0 = 1'b1; d0 = 8'hE2; @(negedge clk);
        chk("F_byte2", 32'({tx_en, tx_d}), 32'({1'b1, 8'hE2}));
        v0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("F_after_rst", 32'({gnt0, gnt1, rdy0, rdy1, tx_en, tx_er, tx_d, busy}), 32'd0);
        chk("F_counters", 32'({frame_cnt, underrun_cnt}), 32'd0);
        req0 = 1'b1;
        pc = 0;
        while (!gnt0 && pc < 60) begin @(negedge clk); pc++; end
        req0 = 1'b0;
        chk("F_regrant", 32'(pc < 60), 32'd1);
        pc = 0;
        stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!stop) begin
                @(negedge clk);
                if (tx_en && tx_d == 8'h55) pc++;
                else stop = 1'b1;
            end
        end
        chk("F_preamble_len", 32'(pc), 32'd7);
        chk("F_sfd", 32'({tx_en, tx_d}), 32'({1'b1, 8'hD5}));
        wait_idle("F_idle");
        chk("F_underrun", 32'(underrun_cnt), 32'd1);

        // underrun_cnt saturation.
        do_reset();
        for (int i = 0; i < 255; i++) underrun_frame();
        chk("G_underrun_255", 32'(underrun_cnt), 32'hFF);
        for (int i = 0; i < 2; i++) underrun_frame();
        chk("G_underrun_sat", 32'(underrun_cnt), 32'hFF);
        chk("G_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
